// File: rtl/fft8_stream_ctrl.sv
// fft8_stream_ctrl: serial-to-parallel wrapper around the 8-point FFT datapath.
// Collects 8 complex samples, fires fft8 once, waits (with timeout) for the
// result, then streams y0..y7 out with valid/ready. No arithmetic on data.
module fft8_stream_ctrl #(
  parameter int DW      = 24,
  parameter int TIMEOUT = 64,
  parameter int CW      = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [DW-1:0]   s_real,
  input  logic [DW-1:0]   s_imag,
  output logic            fft_en,
  output logic [8*DW-1:0] fft_x_real,
  output logic [8*DW-1:0] fft_x_imag,
  input  logic            fft_valid,
  input  logic [8*DW-1:0] fft_y_real,
  input  logic [8*DW-1:0] fft_y_imag,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [DW-1:0]   m_real,
  output logic [DW-1:0]   m_imag,
  output logic            m_last,
  output logic            busy,
  output logic            timeout_err,
  output logic [CW-1:0]   frame_cnt,
  output logic [CW-1:0]   err_cnt
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_FIRE  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t         state_r;
  state_t         state_nxt_s;
  logic [2:0]     in_idx_r;
  logic [2:0]     out_idx_r;
  logic [TW-1:0]  timer_r;
  logic [CW-1:0]  frame_cnt_r;
  logic [CW-1:0]  err_cnt_r;
  logic [DW-1:0]  in_re_r  [8];
  logic [DW-1:0]  in_im_r  [8];
  logic [DW-1:0]  out_re_r [8];
  logic [DW-1:0]  out_im_r [8];

  logic in_hs_s;
  logic out_hs_s;
  logic abort_s;
  logic capture_s;

  assign in_hs_s   = (state_r == ST_FILL) && s_valid;
  assign out_hs_s  = (state_r == ST_DRAIN) && m_ready;
  // A response on the terminal-count cycle is captured, not aborted.
  assign capture_s = (state_r == ST_WAIT) && fft_valid;
  assign abort_s   = (state_r == ST_WAIT) && !fft_valid && (timer_r == TW'(TIMEOUT - 1));

  // Next-state decode for the fill / fire / wait / drain sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_FILL: begin
        if (in_hs_s && (in_idx_r == 3'd7)) state_nxt_s = ST_FIRE;
        else                               state_nxt_s = ST_FILL;
      end
      ST_FIRE: state_nxt_s = ST_WAIT;
      ST_WAIT: begin
        if (capture_s)    state_nxt_s = ST_DRAIN;
        else if (abort_s) state_nxt_s = ST_FILL;
        else              state_nxt_s = ST_WAIT;
      end
      ST_DRAIN: begin
        if (out_hs_s && (out_idx_r == 3'd7)) state_nxt_s = ST_FILL;
        else                                 state_nxt_s = ST_DRAIN;
      end
      default: state_nxt_s = ST_FILL;
    endcase
  end

  // State, indices, timer and counters; buffers are left unreset since they are never emitted stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_FILL;
      in_idx_r    <= 3'd0;
      out_idx_r   <= 3'd0;
      timer_r     <= '0;
      frame_cnt_r <= '0;
      err_cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        ST_FILL: begin
          if (in_hs_s) in_idx_r <= in_idx_r + 3'd1;
        end
        ST_FIRE: timer_r <= '0;
        ST_WAIT: begin
          timer_r <= timer_r + TW'(1);
          if (abort_s && !capture_s) begin
            err_cnt_r <= err_cnt_r + CW'(1);
            in_idx_r  <= 3'd0;
          end
        end
        ST_DRAIN: begin
          if (out_hs_s) begin
            out_idx_r <= out_idx_r + 3'd1;
            if (out_idx_r == 3'd7) begin
              frame_cnt_r <= frame_cnt_r + CW'(1);
              in_idx_r    <= 3'd0;
            end
          end
        end
        default: state_r <= ST_FILL;
      endcase
    end
  end

  // Sample buffer write on each accepted input.
  always_ff @(posedge clk) begin
    if (in_hs_s) begin
      in_re_r[in_idx_r] <= s_real;
      in_im_r[in_idx_r] <= s_imag;
    end
  end

  // Result buffer capture when fft8 answers during WAIT.
  always_ff @(posedge clk) begin
    if (capture_s) begin
      for (int i = 0; i < 8; i++) begin
        out_re_r[i] <= fft_y_real[DW*i +: DW];
        out_im_r[i] <= fft_y_imag[DW*i +: DW];
      end
    end
  end

  // Pack the input buffer onto the fft8 operand bus; stable while no samples are accepted.
  always_comb begin
    fft_x_real = '0;
    fft_x_imag = '0;
    for (int i = 0; i < 8; i++) begin
      fft_x_real[DW*i +: DW] = in_re_r[i];
      fft_x_imag[DW*i +: DW] = in_im_r[i];
    end
  end

  // Stream-side outputs decoded from registered state only (timeout_err also qualifies on fft_valid).
  always_comb begin
    s_ready     = (state_r == ST_FILL);
    fft_en      = (state_r == ST_FIRE);
    m_valid     = (state_r == ST_DRAIN);
    busy        = !((state_r == ST_FILL) && (in_idx_r == 3'd0));
    timeout_err = abort_s;
    frame_cnt   = frame_cnt_r;
    err_cnt     = err_cnt_r;
    if (state_r == ST_DRAIN) begin
      m_real = out_re_r[out_idx_r];
      m_imag = out_im_r[out_idx_r];
      m_last = (out_idx_r == 3'd7);
    end else begin
      m_real = '0;
      m_imag = '0;
      m_last = 1'b0;
    end
  end

endmodule

// File: tb/tb_fft8_stream_ctrl.sv
// Bench for fft8_stream_ctrl: a cycle table for the basic frame plus
// directed sequences for stalls, timeout, mid-frame reset, gaps and DC input.
module tb_fft8_stream_ctrl;
  localparam int DW = 24;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            s_valid, s_ready;
  logic [DW-1:0]   s_real, s_imag;
  logic            fft_en;
  logic [8*DW-1:0] fft_x_real, fft_x_imag;
  logic            fft_valid;
  logic [8*DW-1:0] fft_y_real, fft_y_imag;
  logic            m_valid, m_ready;
  logic [DW-1:0]   m_real, m_imag;
  logic            m_last, busy, timeout_err;
  logic [CW-1:0]   frame_cnt, err_cnt;

  int checks = 0;
  int errors = 0;

  // Stub: 0 = 3-cycle echo, 1 = never answers, 2 = DC sum in y0
  int              stub_mode = 0;
  logic            spur = 1'b0;
  logic [2:0]      en_d = 3'b000;
  logic [8*DW-1:0] cap_re = '0, cap_im = '0;

  logic [DW-1:0] exp_re [8];
  logic [DW-1:0] exp_im [8];

  fft8_stream_ctrl #(.DW(DW), .TIMEOUT(64), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_real(s_real), .s_imag(s_imag),
    .fft_en(fft_en), .fft_x_real(fft_x_real), .fft_x_imag(fft_x_imag),
    .fft_valid(fft_valid), .fft_y_real(fft_y_real), .fft_y_imag(fft_y_imag),
    .m_valid(m_valid), .m_ready(m_ready), .m_real(m_real), .m_imag(m_imag),
    .m_last(m_last), .busy(busy), .timeout_err(timeout_err),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // fft8 stand-in pipeline: latch operands on en, answer three cycles later
  always_ff @(posedge clk) begin
    en_d <= {en_d[1:0], fft_en};
    if (fft_en) begin
      cap_re <= fft_x_real;
      cap_im <= fft_x_imag;
    end
  end

  // fft8 stand-in response
  always_comb begin
    logic signed [DW+3:0] sr, si;
    sr = '0;
    si = '0;
    fft_valid = spur || ((stub_mode != 1) && en_d[2]);
    fft_y_real = cap_re;
    fft_y_imag = cap_im;
    if (stub_mode == 2) begin
      for (int i = 0; i < 8; i++) begin
        sr = sr + (DW+4)'($signed(cap_re[DW*i +: DW]));
        si = si + (DW+4)'($signed(cap_im[DW*i +: DW]));
      end
      fft_y_real = '0;
      fft_y_imag = '0;
      fft_y_real[DW-1:0] = sr[DW-1:0];
      fft_y_imag[DW-1:0] = si[DW-1:0];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; spur = 1'b0;
    s_real = '0; s_imag = '0;
    tick();
    rst = 1'b0;
  endtask

  // Send exp_re/exp_im[0..n-1]; optional random idle gaps and one spurious fft_valid
  task automatic send_frame(input int n, input bit gaps, input bit spurious);
    int j = 0;
    int cyc = 0;
    while (j < n && cyc < 200) begin
      if (spurious && j == 3) begin
        s_valid = 1'b0; spur = 1'b1;
        tick();
        spur = 1'b0;
      end
      if (gaps && $urandom_range(0, 2) == 0) begin
        s_valid = 1'b0;
        tick();
      end
      s_valid = 1'b1; s_real = exp_re[j]; s_imag = exp_im[j];
      @(negedge clk);
      if (s_ready) j++;
      tick();
      cyc++;
    end
    s_valid = 1'b0;
    if (j < n) chk("send_budget", 64'(j), 64'(n));
  endtask

  // Drain one frame against exp_*; toggle=1 drives m_ready 1,0,1,0...
  task automatic recv_frame(input bit toggle);
    int k = 0;
    int cyc = 0;
    while (k < 8 && cyc < 300) begin
      m_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
      @(negedge clk);
      chk("s_ready_busy", 64'(s_ready), 64'd0);
      if (m_valid) begin
        chk("m_real", 64'(m_real), 64'(exp_re[k]));
        chk("m_imag", 64'(m_imag), 64'(exp_im[k]));
        chk("m_last", 64'(m_last), 64'(k == 7));
        if (m_ready) k++;
      end
      tick();
      cyc++;
    end
    m_ready = 1'b0;
    if (k < 8) chk("recv_budget", 64'(k), 64'd8);
    @(negedge clk);
    chk("s_ready_after", 64'(s_ready), 64'd1);
    chk("m_valid_after", 64'(m_valid), 64'd0);
    tick();
  endtask

  typedef struct {
    logic          s_valid;
    logic [DW-1:0] s_re, s_im;
    logic          m_ready;
    logic          e_s_ready, e_fft_en, e_m_valid, e_m_last;
    logic [DW-1:0] e_m_re, e_m_im;
  } vec_t;

  vec_t vt [21];

  initial begin
    int n;
    // Cycle table for one frame, 3-cycle echo, m_ready high
    for (int i = 0; i < 21; i++) begin
      vt[i] = '{1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0};
      if (i < 8) begin
        vt[i].s_valid = 1'b1;
        vt[i].s_re = DW'(i + 1);
        vt[i].s_im = DW'(-(i + 1));
        vt[i].e_s_ready = 1'b1;
      end
      if (i == 8) vt[i].e_fft_en = 1'b1;
      if (i >= 12 && i <= 19) begin
        vt[i].e_m_valid = 1'b1;
        vt[i].e_m_re = DW'(i - 11);
        vt[i].e_m_im = DW'(-(i - 11));
        vt[i].e_m_last = (i == 19);
      end
      if (i == 20) vt[i].e_s_ready = 1'b1;
    end

    rst = 1'b1;
    s_valid = 1'b0; m_ready = 1'b0; s_real = '0; s_imag = '0;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_s_ready", 64'(s_ready), 64'd1);
    chk("rst_fft_en", 64'(fft_en), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_last", 64'(m_last), 64'd0);
    chk("rst_m_real", 64'(m_real), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_terr", 64'(timeout_err), 64'd0);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    tick();

    // 1) table-driven basic frame
    for (int i = 0; i < 21; i++) begin
      s_valid = vt[i].s_valid; s_real = vt[i].s_re; s_imag = vt[i].s_im;
      m_ready = vt[i].m_ready;
      @(negedge clk);
      chk("t_s_ready", 64'(s_ready), 64'(vt[i].e_s_ready));
      chk("t_fft_en", 64'(fft_en), 64'(vt[i].e_fft_en));
      chk("t_m_valid", 64'(m_valid), 64'(vt[i].e_m_valid));
      chk("t_m_last", 64'(m_last), 64'(vt[i].e_m_last));
      chk("t_m_real", 64'(m_real), 64'(vt[i].e_m_re));
      chk("t_m_imag", 64'(m_imag), 64'(vt[i].e_m_im));
      tick();
    end
    s_valid = 1'b0;
    @(negedge clk);
    chk("t_frame_cnt", 64'(frame_cnt), 64'd1);
    chk("t_busy_idle", 64'(busy), 64'd0);
    tick();

    // 2) same frame with m_ready toggling
    for (int i = 0; i < 8; i++) begin
      exp_re[i] = DW'(i + 1);
      exp_im[i] = DW'(-(i + 1));
    end
    send_frame(8, 1'b0, 1'b0);
    recv_frame(1'b1);
    @(negedge clk);
    chk("toggle_frame_cnt", 64'(frame_cnt), 64'd2);
    tick();

    // 3) fft8 never answers -> timeout 64 cycles after fft_en
    do_reset();
    stub_mode = 1;
    send_frame(8, 1'b0, 1'b0);
    @(negedge clk);
    chk("to_fft_en", 64'(fft_en), 64'd1);
    n = 0;
    do begin
      tick();
      n++;
      @(negedge clk);
      if (m_valid) chk("to_m_valid", 64'(m_valid), 64'd0);
    end while (!timeout_err && n < 200);
    chk("to_latency", 64'(n), 64'd64);
    tick();
    @(negedge clk);
    chk("to_s_ready", 64'(s_ready), 64'd1);
    chk("to_err_cnt", 64'(err_cnt), 64'd1);
    chk("to_pulse_len", 64'(timeout_err), 64'd0);
    chk("to_busy", 64'(busy), 64'd0);
    tick();
    stub_mode = 0;
    for (int i = 0; i < 8; i++) begin
      exp_re[i] = DW'(32'h30 + i);
      exp_im[i] = DW'(32'h40 + i);
    end
    send_frame(8, 1'b0, 1'b0);
    recv_frame(1'b0);
    @(negedge clk);
    chk("to_next_frame_cnt", 64'(frame_cnt), 64'd1);
    tick();

    // 4) reset after 5 samples, then a fresh frame
    do_reset();
    for (int i = 0; i < 8; i++) begin
      exp_re[i] = DW'(32'h50 + i);
      exp_im[i] = DW'(32'h60 + i);
    end
    send_frame(5, 1'b0, 1'b0);
    @(negedge clk);
    chk("mid_busy", 64'(busy), 64'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_re[i] = DW'(32'h10 + i);
      exp_im[i] = DW'(32'h20 + i);
    end
    send_frame(8, 1'b0, 1'b0);
    recv_frame(1'b0);
    @(negedge clk);
    chk("rst_mid_frame_cnt", 64'(frame_cnt), 64'd1);
    tick();

    // 5) ten frames with gaps and a spurious fft_valid during FILL
    do_reset();
    for (int f = 0; f < 10; f++) begin
      for (int i = 0; i < 8; i++) begin
        exp_re[i] = DW'(f * 16 + i + 1);
        exp_im[i] = DW'(-(f * 16 + i + 1));
      end
      send_frame(8, 1'b1, (f % 3) == 0);
      recv_frame(f[0]);
    end
    @(negedge clk);
    chk("gap_frame_cnt", 64'(frame_cnt), 64'd10);
    tick();

    // 6) DC input through a summing stand-in for fft8
    do_reset();
    stub_mode = 2;
    for (int i = 0; i < 8; i++) begin
      exp_re[i] = DW'(32'h100);
      exp_im[i] = '0;
    end
    send_frame(8, 1'b0, 1'b0);
    exp_re[0] = DW'(32'h800);
    for (int i = 1; i < 8; i++) exp_re[i] = '0;
    recv_frame(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
